// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encoding and default widths for the trace readout block
package trace_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/trace_rd_skid.sv
// rtl/trace_rd_skid.sv - 2-entry skid buffer carrying payload plus last flag
module trace_rd_skid #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [1:0]       level
);
   logic [WIDTH-1:0] d0, d1;
   logic             l0, l1;
   logic [1:0]       cnt;
   logic             pop;

   assign pop       = (cnt != 2'd0) && out_ready;
   assign out_valid = (cnt != 2'd0);
   assign out_data  = d0;
   assign out_last  = l0;
   assign level     = cnt;

   // Entry 0 is always the head, so it never moves while the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= 2'd0;
         d0  <= '0;
         d1  <= '0;
         l0  <= 1'b0;
         l1  <= 1'b0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (cnt == 2'd0) begin
                  d0 <= in_data;
                  l0 <= in_last;
               end else begin
                  d1 <= in_data;
                  l1 <= in_last;
               end
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               d0  <= d1;
               l0  <= l1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  d0 <= in_data;
                  l0 <= in_last;
               end else begin
                  d0 <= d1;
                  l0 <= l1;
                  d1 <= in_data;
                  l1 <= in_last;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/trace_reader.sv
// rtl/trace_reader.sv - trace RAM readout to stream, oldest sample first
// Optional beat ordinal output o_index is enabled by TRACE_READER_INDEX_EN.
module trace_reader import trace_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   input  logic                  o_ready,
   output logic                  busy,
   output logic                  done
`ifdef TRACE_READER_INDEX_EN
   , output logic [ADDR_WIDTH:0] o_index
`endif
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;
`ifdef TRACE_READER_INDEX_EN
   localparam int PW    = DATA_WIDTH + CW;
`else
   localparam int PW    = DATA_WIDTH;
`endif

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] raddr, base;
   logic [CW-1:0]         count_sat, rem_issue;
   logic                  inflight, inflight_last;
   logic [1:0]            level;
   logic [2:0]            occupancy;
   logic                  pop, can_issue, last_issue;
   logic [PW-1:0]         in_payload, out_payload;

   assign count_sat  = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
   assign base       = waddr + ADDR_WIDTH'(1) - count_sat[ADDR_WIDTH-1:0];
   assign pop        = o_valid && o_ready;
   // Reserve room for every read already in flight; a same-cycle pop frees one slot.
   assign occupancy  = {1'b0, level} + {2'b00, inflight};
   assign can_issue  = occupancy <= ({2'b00, pop} + 3'd1);
   assign last_issue = (rem_issue == CW'(1));
   assign mem_raddr  = raddr;

   always_comb begin
      state_next = state;
      mem_ren    = 1'b0;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = (count_sat == '0) ? DONE : STREAM;
         end
         STREAM: begin
            mem_ren = can_issue && !abort;
            if (mem_ren && last_issue) state_next = DRAIN;
         end
         DRAIN: begin
            if (pop && o_last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef TRACE_READER_INDEX_EN
   logic [CW-1:0] idx_issue, inflight_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_issue    <= '0;
         inflight_idx <= '0;
      end else if (state == IDLE) begin
         idx_issue <= '0;
      end else if (mem_ren) begin
         idx_issue    <= idx_issue + CW'(1);
         inflight_idx <= idx_issue;
      end
   end

   assign in_payload = {inflight_idx, mem_rdata};
   assign o_index    = out_payload[DATA_WIDTH +: CW];
`else
   assign in_payload = mem_rdata;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         raddr         <= '0;
         rem_issue     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= abort ? IDLE : state_next;
         inflight      <= mem_ren;
         inflight_last <= mem_ren && last_issue;
         if (state == IDLE && start && !abort) begin
            raddr     <= base;
            rem_issue <= count_sat;
         end else if (mem_ren) begin
            raddr     <= raddr + ADDR_WIDTH'(1);
            rem_issue <= rem_issue - CW'(1);
         end
      end
   end

   trace_rd_skid #(.WIDTH(PW)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (abort),
      .in_valid  (inflight),
      .in_data   (in_payload),
      .in_last   (inflight_last),
      .out_valid (o_valid),
      .out_data  (out_payload),
      .out_last  (o_last),
      .out_ready (o_ready),
      .level     (level)
   );

   assign o_data = out_payload[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_trace_reader.sv
// tb/tb_trace_reader.sv - directed table-driven bench for trace_reader with RAM[i]=i
module tb_trace_reader;
   logic       clk = 1'b0;
   logic       reset, start, abort, o_ready;
   logic [3:0] waddr;
   logic [4:0] count;
   logic       mem_ren;
   logic [3:0] mem_raddr;
   logic [7:0] mem_rdata;
   logic       o_valid, o_last, busy, done;
   logic [7:0] o_data;
`ifdef TRACE_READER_INDEX_EN
   logic [4:0] o_index;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_ren) mem_rdata <= {4'h0, mem_raddr};

   trace_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .waddr     (waddr),
      .count     (count),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .o_valid   (o_valid),
      .o_data    (o_data),
      .o_last    (o_last),
      .o_ready   (o_ready),
      .busy      (busy),
      .done      (done)
`ifdef TRACE_READER_INDEX_EN
      , .o_index (o_index)
`endif
   );

   typedef struct {
      logic [3:0] waddr;
      logic [4:0] count;
      int         mode;
      bit         restart;
      logic [7:0] first;
      int         len;
      logic [7:0] last_d;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic run_case(input vec_t v, input int id);
      int         k = 0, last_cyc = -10, lat = -1;
      logic [7:0] prev_d = 0;
      logic [3:0] e;
      bit         prev_stall = 0, got_done = 0;
      @(negedge clk);
      waddr = v.waddr; count = v.count; start = 1'b1; o_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc < 400; cyc++) begin
         if (cyc > 1) @(negedge clk);
         case (v.mode)
            0:       o_ready = 1'b1;
            1:       o_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: o_ready = 1'($urandom_range(0, 1));
         endcase
         if (v.restart && cyc == 6) begin start = 1'b1; waddr = 4'd0; end
         else begin start = 1'b0; waddr = v.waddr; end
         #1;
         if (o_valid && lat < 0) lat = cyc;
         if (cyc == 2) check($sformatf("c%0d busy_running", id), busy, 1);
         if (prev_stall) begin
            check($sformatf("c%0d stall_valid", id), o_valid, 1);
            check($sformatf("c%0d stall_data", id), o_data, prev_d);
         end
         if (done) begin
            got_done = 1;
            check($sformatf("c%0d done_timing", id), cyc, last_cyc + 1);
            break;
         end
         if (o_valid && o_ready) begin
            e = v.first[3:0] + 4'(k);
            check($sformatf("c%0d beat%0d_data", id, k), o_data, {4'h0, e});
            check($sformatf("c%0d beat%0d_last", id, k), o_last, (k == v.len - 1));
`ifdef TRACE_READER_INDEX_EN
            check($sformatf("c%0d beat%0d_index", id, k), o_index, k);
`endif
            if (o_last) begin
               check($sformatf("c%0d last_data", id), o_data, v.last_d);
               last_cyc = cyc;
            end
            k++;
         end
         prev_stall = o_valid && !o_ready;
         prev_d     = o_data;
      end
      start = 1'b0; waddr = v.waddr;
      check($sformatf("c%0d done_seen", id), got_done, 1);
      check($sformatf("c%0d beat_count", id), k, v.len);
      check($sformatf("c%0d first_latency", id), lat, 3);
      @(negedge clk); #1;
      check($sformatf("c%0d done_one_cycle", id), done, 0);
      check($sformatf("c%0d busy_after", id), busy, 0);
   endtask

   // Interrupt a full readout after 5 accepted beats with abort or reset.
   task automatic interrupt(input bit use_reset);
      string tag = use_reset ? "rst" : "abt";
      @(negedge clk);
      waddr = 4'd5; count = 5'd16; start = 1'b1; o_ready = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (cyc == 7) check({tag, " beat5_data"}, o_data, 10);
      end
      @(negedge clk);
      if (use_reset) reset = 1'b1; else abort = 1'b1;
      o_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0; abort = 1'b0;
      #1;
      check({tag, " valid_cleared"}, o_valid, 0);
      check({tag, " busy_cleared"}, busy, 0);
      check({tag, " no_done"}, done, 0);
      if (use_reset) begin
         check({tag, " raddr_zero"}, mem_raddr, 0);
         check({tag, " data_zero"}, o_data, 0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         check({tag, " quiet"}, {o_valid, done, busy}, 0);
      end
   endtask

   initial begin
      vecs[0] = '{waddr: 5,  count: 16, mode: 0, restart: 0, first: 6,  len: 16, last_d: 5};
      vecs[1] = '{waddr: 1,  count: 3,  mode: 0, restart: 0, first: 15, len: 3,  last_d: 1};
      vecs[2] = '{waddr: 5,  count: 16, mode: 1, restart: 0, first: 6,  len: 16, last_d: 5};
      vecs[3] = '{waddr: 0,  count: 1,  mode: 0, restart: 0, first: 0,  len: 1,  last_d: 0};
      vecs[4] = '{waddr: 15, count: 16, mode: 2, restart: 0, first: 0,  len: 16, last_d: 15};
      vecs[5] = '{waddr: 3,  count: 20, mode: 0, restart: 0, first: 4,  len: 16, last_d: 3};
      vecs[6] = '{waddr: 9,  count: 5,  mode: 2, restart: 1, first: 5,  len: 5,  last_d: 9};
      vecs[7] = '{waddr: 5,  count: 16, mode: 0, restart: 1, first: 6,  len: 16, last_d: 5};

      reset = 1'b1; start = 1'b0; abort = 1'b0; o_ready = 1'b0;
      waddr = 4'd0; count = 5'd0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {o_valid, o_last, mem_ren, busy, done}, 0);
      check("reset_data", o_data, 0);
      check("reset_raddr", mem_raddr, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_case(vecs[i], i);

      // count=0: straight to DONE for a single cycle
      @(negedge clk);
      count = 5'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("zero done", done, 1);
      check("zero busy", busy, 1);
      check("zero valid", o_valid, 0);
      @(negedge clk); #1;
      check("zero after", {done, busy, o_valid}, 0);

      // abort wins over a same-cycle start in IDLE
      @(negedge clk);
      count = 5'd4; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      check("abort_priority busy", busy, 0);

      interrupt(1'b0);
      run_case(vecs[0], 10);
      interrupt(1'b1);
      run_case(vecs[0], 11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
